// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the input-conditioner family (switches, buttons, encoders):
// debouncer FSM encoding and counter sizing.
package sw_debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_e;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch conditioner bundle: raw pins in, clean level plus edge pulses out.
interface sw_debounce_if #(
    parameter int SW_NUM = 3
);
    logic [SW_NUM-1:0] sw_raw;
    logic [SW_NUM-1:0] sw_db;
    logic [SW_NUM-1:0] sw_rise;
    logic [SW_NUM-1:0] sw_fall;

    modport master (
        output sw_raw,
        input  sw_db,
        input  sw_rise,
        input  sw_fall
    );

    modport slave (
        input  sw_raw,
        output sw_db,
        output sw_rise,
        output sw_fall
    );
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch: two-flop synchronizer, then a counter FSM that accepts a new level
// only after DEBOUNCE_CYCLES consecutive differing samples.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw_raw,
    output logic o_sw_db,
    output logic o_sw_rise,
    output logic o_sw_fall
);
    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          r_meta;
    logic          r_sync;
    db_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;

    db_state_e     w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_db_next;
    logic          w_rise_next;
    logic          w_fall_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_meta  <= i_sw_raw;
            r_sync  <= r_meta;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_db    <= w_db_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_db_next    = r_db;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        unique case (r_state)
            ST_STABLE: begin
                w_cnt_next = '0;
                if (r_sync != r_db) begin
                    w_state_next = ST_COUNT;
                    w_cnt_next   = CNT_ONE;
                end
            end
            ST_COUNT: begin
                // Any sample matching the current level aborts and restarts qualification.
                if (r_sync == r_db) begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = '0;
                    w_db_next    = r_sync;
                    w_rise_next  = r_sync;
                    w_fall_next  = ~r_sync;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_STABLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_sw_db   = r_db;
    assign o_sw_rise = r_rise;
    assign o_sw_fall = r_fall;

endmodule

// File: rtl/sw_debounce.sv
// Bank of independent switch debouncers; sw_db feeds the LED controller's sw input.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int SW_NUM          = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    sw_debounce_if.slave  bus
);
    logic [SW_NUM-1:0] w_sw_db;
    logic [SW_NUM-1:0] w_sw_rise;
    logic [SW_NUM-1:0] w_sw_fall;

    generate
        for (genvar gi = 0; gi < SW_NUM; gi++) begin : g_bit
            sw_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk       (clk),
                .reset     (reset),
                .i_sw_raw  (bus.sw_raw[gi]),
                .o_sw_db   (w_sw_db[gi]),
                .o_sw_rise (w_sw_rise[gi]),
                .o_sw_fall (w_sw_fall[gi])
            );
        end
    endgenerate

    assign bus.sw_db   = w_sw_db;
    assign bus.sw_rise = w_sw_rise;
    assign bus.sw_fall = w_sw_fall;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4: every cycle's expected
// outputs are queued as the stimulus is driven and checked after the clock edge.
module tb_sw_debounce;
    localparam int SW_NUM = 3;
    localparam int DC     = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sw_debounce_if #(.SW_NUM(SW_NUM)) bus ();

    sw_debounce #(
        .SW_NUM          (SW_NUM),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [8:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    // One clock: drive inputs, queue the outputs expected after the edge, compare.
    task automatic apply(input string tag, input logic rst, input logic [2:0] raw,
                         input logic [2:0] edb, input logic [2:0] erise, input logic [2:0] efall);
        logic [8:0] exp_v;
        logic [8:0] got_v;
        reset      = rst;
        bus.sw_raw = raw;
        exp_q.push_back({edb, erise, efall});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        got_v = {bus.sw_db, bus.sw_rise, bus.sw_fall};
        n_vec++;
        assert (got_v === exp_v) else begin
            n_err++;
            $error("FAIL %s vec %0d: got db=%b rise=%b fall=%b, want db=%b rise=%b fall=%b",
                   tag, n_vec, got_v[8:6], got_v[5:3], got_v[2:0],
                   exp_v[8:6], exp_v[5:3], exp_v[2:0]);
        end
    endtask

    task automatic hold(input string tag, input int n, input logic rst, input logic [2:0] raw,
                        input logic [2:0] edb, input logic [2:0] erise, input logic [2:0] efall);
        for (int i = 0; i < n; i++) apply(tag, rst, raw, edb, erise, efall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with switches high, then fresh rise at release edge +5.
        hold ("reset_hold",   3, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
        hold ("post_reset",   5, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        apply("reset_rise",      1'b0, 3'b111, 3'b111, 3'b111, 3'b000);
        hold ("reset_after",  2, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000);

        // Return to all-low via reset.
        hold ("clear_reset",  2, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
        hold ("clear_idle",   3, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);

        // Clean rise on bit 0.
        hold ("clean_wait",   5, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        apply("clean_rise",      1'b0, 3'b001, 3'b001, 3'b001, 3'b000);
        hold ("clean_after",  2, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);

        // 3-cycle glitch on bit 1 is rejected.
        hold ("glitch3_hi",   3, 1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        hold ("glitch3_lo",   6, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);

        // 4-cycle pulse on bit 1 is accepted, then falls 5 edges after release.
        hold ("pulse4_hi",    4, 1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        apply("pulse4_lo",       1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        apply("pulse4_rise",     1'b0, 3'b001, 3'b011, 3'b010, 3'b000);
        hold ("pulse4_hold",  3, 1'b0, 3'b001, 3'b011, 3'b000, 3'b000);
        apply("pulse4_fall",     1'b0, 3'b001, 3'b001, 3'b000, 3'b010);
        apply("pulse4_after",    1'b0, 3'b001, 3'b001, 3'b000, 3'b000);

        // Bounce on bit 2: 1,0,1,0,1 then held; one rise 4 edges after last sync return.
        apply("bounce",          1'b0, 3'b101, 3'b001, 3'b000, 3'b000);
        apply("bounce",          1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        apply("bounce",          1'b0, 3'b101, 3'b001, 3'b000, 3'b000);
        apply("bounce",          1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        hold ("bounce_hold",  5, 1'b0, 3'b101, 3'b001, 3'b000, 3'b000);
        apply("bounce_rise",     1'b0, 3'b101, 3'b101, 3'b100, 3'b000);
        hold ("bounce_after", 2, 1'b0, 3'b101, 3'b101, 3'b000, 3'b000);

        // Bits 0 and 2 fall together.
        hold ("dual_fall_w",  5, 1'b0, 3'b000, 3'b101, 3'b000, 3'b000);
        apply("dual_fall",       1'b0, 3'b000, 3'b000, 3'b000, 3'b101);
        hold ("dual_after",   2, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);

        // All bits rise on the same edge.
        hold ("simul_wait",   5, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        apply("simul_rise",      1'b0, 3'b111, 3'b111, 3'b111, 3'b000);
        hold ("simul_after",  2, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000);

        // Bit 0 falls cleanly while bit 1 bounces low and returns high.
        apply("mix",             1'b0, 3'b100, 3'b111, 3'b000, 3'b000);
        apply("mix",             1'b0, 3'b110, 3'b111, 3'b000, 3'b000);
        apply("mix",             1'b0, 3'b100, 3'b111, 3'b000, 3'b000);
        hold ("mix",          2, 1'b0, 3'b110, 3'b111, 3'b000, 3'b000);
        apply("mix_fall0",       1'b0, 3'b110, 3'b110, 3'b000, 3'b001);
        hold ("mix_after",    4, 1'b0, 3'b110, 3'b110, 3'b000, 3'b000);

        // Reset while bit 0 is mid-count (cnt=2): no pulse, full re-qualification.
        hold ("midcnt_count", 4, 1'b0, 3'b111, 3'b110, 3'b000, 3'b000);
        hold ("midcnt_reset", 2, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
        hold ("midcnt_wait",  5, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        apply("midcnt_rise",     1'b0, 3'b111, 3'b111, 3'b111, 3'b000);
        hold ("midcnt_after", 2, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
